toilet_assay_seq: RTL and testbench

- Timed valve sequencer for the smart-toilet mixing chain (three inlets: soln1, soln2, soln3; two mixers in series; output serpentine).
- Opens the inlet valves in staggered order, so the long soln3 serpentine path and the four-stage soln2 path fill before soln1 is admitted.
- Routes the chain outlet to waste while priming, then to collect for a programmed dose time.
- Sits in the control plane beside the fluidic netlist. Drives pneumatic valve enables, which are registered levels.

---
 rtl/toilet_assay_seq.sv | 139 +++++++++++++
 tb/tb_toilet_assay_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/toilet_assay_seq.sv
// toilet_assay_seq: timed valve sequencer for the smart-toilet mixing chain.
// Opens the inlets in staggered order (soln3, then soln2, then soln1) with the
// outlet on waste while the chain primes, then switches the outlet to collect
// for the latched dose time.
// Optional feature: define TOILET_SEQ_FLUSH_EN to add a FLUSH state (inlets
// closed, outlet to waste) after every normal run and every abort.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin an assay (accepted only in IDLE without abort)
//   abort              terminate the current assay (ignored during FLUSH)
//   cfg_dose           collect duration in ticks, latched on accepted start
//   valve_soln1/2/3    inlet valve enables
//   valve_waste        outlet to waste
//   valve_collect      outlet to collect
//   busy               high in every state except IDLE
//   done, aborted      one-cycle completion / abort pulses
//   state              IDLE=0 PRIME3=1 PRIME2=2 MIX=3 COLLECT=4 FLUSH=5
module toilet_assay_seq #(
    parameter int TICK_DIV = 4,
    parameter int CW       = 16,
    parameter int PRIME3_T = 40,
    parameter int PRIME2_T = 16,
    parameter int MIX_T    = 8,
    parameter int FLUSH_T  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cfg_dose,
    output logic          valve_soln1,
    output logic          valve_soln2,
    output logic          valve_soln3,
    output logic          valve_waste,
    output logic          valve_collect,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [2:0]    state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME3  = 3'd1,
        PRIME2  = 3'd2,
        MIX     = 3'd3,
        COLLECT = 3'd4,
        FLUSH   = 3'd5
    } state_t;

`ifdef TOILET_SEQ_FLUSH_EN
    localparam state_t FIN  = FLUSH;
    localparam bit     FEAT = 1'b1;
`else
    localparam state_t FIN  = IDLE;
    localparam bit     FEAT = 1'b0;
`endif

    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    // Counter preloads are duration-1; a zero duration is treated as one tick.
    localparam logic [CW-1:0] L3 = CW'(PRIME3_T > 1 ? PRIME3_T - 1 : 0);
    localparam logic [CW-1:0] L2 = CW'(PRIME2_T > 1 ? PRIME2_T - 1 : 0);
    localparam logic [CW-1:0] LM = CW'(MIX_T > 1 ? MIX_T - 1 : 0);
    localparam logic [CW-1:0] LF = CW'(FLUSH_T > 1 ? FLUSH_T - 1 : 0);

    state_t        st, nxt;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt, dose, ld;
    logic [4:0]    vlv;
    logic          tick, expd, pend, pend_n, done_n, abt_n;

    assign tick  = div == DW'(TICK_DIV - 1);
    assign expd  = tick && cnt == '0;
    assign state = st;

    always_comb begin
        nxt    = st;
        pend_n = pend;
        done_n = 1'b0;
        abt_n  = 1'b0;
        case (st)
            IDLE: if (start && !abort) nxt = PRIME3;
            FLUSH: if (expd) begin
                nxt    = IDLE;
                done_n = !pend;
                abt_n  = pend;
                pend_n = 1'b0;
            end
            default: if (abort) begin
                nxt    = FIN;
                pend_n = FEAT;
                abt_n  = !FEAT;
            end else if (expd) begin
                nxt    = st == PRIME3 ? PRIME2 :
                         st == PRIME2 ? MIX :
                         (st == MIX && dose != '0) ? COLLECT : FIN;
                done_n = nxt == IDLE;
            end
        endcase
        ld  = nxt == PRIME3  ? L3 :
              nxt == PRIME2  ? L2 :
              nxt == MIX     ? LM :
              nxt == COLLECT ? dose - 1'b1 : LF;
        // {soln1, soln2, soln3, waste, collect} for the state being entered
        vlv = nxt == PRIME3  ? 5'b00110 :
              nxt == PRIME2  ? 5'b01110 :
              nxt == MIX     ? 5'b11110 :
              nxt == COLLECT ? 5'b11101 :
              nxt == FLUSH   ? 5'b00010 : 5'b00000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            div  <= '0;
            cnt  <= '0;
            dose <= '0;
            pend <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
            {valve_soln1, valve_soln2, valve_soln3, valve_waste, valve_collect} <= '0;
        end else begin
            st      <= nxt;
            pend    <= pend_n;
            busy    <= nxt != IDLE;
            done    <= done_n;
            aborted <= abt_n;
            {valve_soln1, valve_soln2, valve_soln3, valve_waste, valve_collect} <= vlv;
            // divider idles at zero so the first tick lands TICK_DIV cycles into PRIME3
            div <= (st == IDLE || tick) ? '0 : div + 1'b1;
            if (st == IDLE && nxt == PRIME3)
                dose <= cfg_dose;
            if (nxt != st)
                cnt <= ld;
            else if (tick && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_toilet_assay_seq.sv
// tb_toilet_assay_seq: directed and randomized checks of toilet_assay_seq
// against a per-cycle stage-length model, for TICK_DIV=1 and TICK_DIV=3.
module tb_toilet_assay_seq;
    localparam int P3 = 4, P2 = 3, MX = 2, FT = 2;
`ifdef TOILET_SEQ_FLUSH_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] cfg_dose = 16'd5;
    logic a_s1, a_s2, a_s3, a_w, a_c, a_busy, a_done, a_abt;
    logic b_s1, b_s2, b_s3, b_w, b_c, b_busy, b_done, b_abt;
    logic [2:0] a_state, b_state;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    toilet_assay_seq #(.TICK_DIV(1), .CW(16), .PRIME3_T(P3), .PRIME2_T(P2), .MIX_T(MX), .FLUSH_T(FT)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_dose(cfg_dose),
        .valve_soln1(a_s1), .valve_soln2(a_s2), .valve_soln3(a_s3), .valve_waste(a_w),
        .valve_collect(a_c), .busy(a_busy), .done(a_done), .aborted(a_abt), .state(a_state));

    toilet_assay_seq #(.TICK_DIV(3), .CW(16), .PRIME3_T(P3), .PRIME2_T(P2), .MIX_T(MX), .FLUSH_T(FT)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(1'b0), .cfg_dose(cfg_dose),
        .valve_soln1(b_s1), .valve_soln2(b_s2), .valve_soln3(b_s3), .valve_waste(b_w),
        .valve_collect(b_c), .busy(b_busy), .done(b_done), .aborted(b_abt), .state(b_state));

    // Model: current stage, cycles left in it, latched dose, pending-abort flag.
    typedef struct {
        int st; int left; int dose; bit pend; bit done; bit abt;
    } mdl_t;
    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, bit s, bit a, int d, int td);
        mdl_t n = m;
        n.done = 0;
        n.abt  = 0;
        if (m.st == 0) begin
            if (s && !a) begin n.st = 1; n.left = P3 * td; n.dose = d; end
        end else if (a && m.st != 5) begin
            if (FE) begin n.st = 5; n.left = FT * td; n.pend = 1; end
            else begin n.st = 0; n.abt = 1; end
        end else if (m.left > 1) begin
            n.left = m.left - 1;
        end else begin
            case (m.st)
                1: begin n.st = 2; n.left = P2 * td; end
                2: begin n.st = 3; n.left = MX * td; end
                3, 4: begin
                    if (m.st == 3 && m.dose != 0) begin n.st = 4; n.left = m.dose * td; end
                    else if (FE) begin n.st = 5; n.left = FT * td; end
                    else begin n.st = 0; n.done = 1; end
                end
                default: begin n.st = 0; n.done = !m.pend; n.abt = m.pend; n.pend = 0; end
            endcase
        end
        return n;
    endfunction

    function automatic logic [10:0] expo(mdl_t m);
        logic [4:0] v;
        v = m.st == 1 ? 5'b00110 : m.st == 2 ? 5'b01110 : m.st == 3 ? 5'b11110 :
            m.st == 4 ? 5'b11101 : m.st == 5 ? 5'b00010 : 5'b00000;
        return {3'(m.st), v, m.st != 0, m.done, m.abt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= step(ma, start, abort, int'(cfg_dose), 1);
            mb <= step(mb, start, 1'b0, int'(cfg_dose), 3);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_model", {21'd0, a_state, a_s1, a_s2, a_s3, a_w, a_c, a_busy, a_done, a_abt}, {21'd0, expo(ma)});
            chk("b_model", {21'd0, b_state, b_s1, b_s2, b_s3, b_w, b_c, b_busy, b_done, b_abt}, {21'd0, expo(mb)});
        end
    end

    int lg_st[1:64], lg_done[1:64], lg_abt[1:64], lg_busy[1:64], lg_c[1:64];
    logic [4:0] lg_v[1:64];
    int b_busy_n;

    // Runs n cycles from cycle 1 of an assay; abort during cycle ab_at, optional
    // start re-assertion with a new dose during cycle 3.
    task automatic run(input int n, input int ab_at, input bit restart);
        b_busy_n = 0;
        for (int i = 1; i <= n; i++) begin
            abort = (i == ab_at);
            start = restart && i == 3;
            if (restart && i == 3) cfg_dose = 16'd9;
            @(negedge clk);
            lg_st[i] = int'(a_state);
            lg_v[i] = {a_s1, a_s2, a_s3, a_w, a_c};
            lg_done[i] = int'(a_done);
            lg_abt[i] = int'(a_abt);
            lg_busy[i] = int'(a_busy);
            lg_c[i] = int'(a_c);
            b_busy_n += int'(b_busy);
            @(posedge clk); #1;
        end
        abort = 0;
        start = 0;
    endtask

    task automatic kick(input logic [15:0] d);
        cfg_dose = d;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    function automatic int first_of(input int n, input bit want_done);
        for (int i = 1; i <= n; i++)
            if ((want_done ? lg_done[i] : lg_abt[i]) != 0) return i;
        return 0;
    endfunction

    function automatic int sum_of(input int n, input int sel);
        int s = 0;
        for (int i = 1; i <= n; i++)
            s += sel == 0 ? lg_done[i] : sel == 1 ? lg_abt[i] : sel == 2 ? lg_busy[i] : lg_c[i];
        return s;
    endfunction

    initial begin
        @(posedge clk); @(negedge clk);
        chk("reset_outputs", {a_state, a_s1, a_s2, a_s3, a_w, a_c, a_busy, a_done, a_abt}, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        kick(16'd5);
        run(60, 0, 1);
        chk("p3_first", lg_st[1], 1);
        chk("p3_last", lg_st[4], 1);
        chk("p2_first", lg_st[5], 2);
        chk("mix_first", lg_st[8], 3);
        chk("collect_first", lg_st[10], 4);
        chk("collect_last_dose5", lg_st[14], 4);
        chk("after_collect", lg_st[15], FE ? 5 : 0);
        chk("valves_p3", lg_v[2], 5'b00110);
        chk("valves_p2", lg_v[6], 5'b01110);
        chk("valves_mix", lg_v[9], 5'b11110);
        chk("valves_collect", lg_v[12], 5'b11101);
        chk("done_cycle", first_of(60, 1), FE ? 17 : 15);
        chk("done_count", sum_of(60, 0), 1);
        chk("a_busy_cycles", sum_of(60, 2), FE ? 16 : 14);
        chk("b_busy_cycles", b_busy_n, FE ? 48 : 42);
        cfg_dose = 16'd5;

        kick(16'd5);
        run(20, 11, 0);
        chk("abort_prev_state", lg_st[11], 4);
        chk("abort_next_state", lg_st[12], FE ? 5 : 0);
        chk("abort_next_valves", lg_v[12], FE ? 5'b00010 : 5'b00000);
        chk("abort_pulse_cycle", first_of(20, 0), FE ? 14 : 12);
        chk("abort_pulse_count", sum_of(20, 1), 1);
        chk("abort_no_done", sum_of(20, 0), 0);

        start = 1;
        abort = 1;
        @(posedge clk); #1;
        start = 0;
        abort = 0;
        @(negedge clk);
        chk("start_abort_idle_state", a_state, 0);
        chk("start_abort_idle_busy", a_busy, 0);
        repeat (60) @(posedge clk);
        #1;

        kick(16'd0);
        run(20, 0, 0);
        chk("zero_dose_no_collect", sum_of(20, 3), 0);
        chk("zero_dose_done_cycle", first_of(20, 1), FE ? 12 : 10);
        chk("zero_dose_after_mix", lg_st[10], FE ? 5 : 0);

        kick(16'd5);
        run(6, 0, 0);
        chk("pre_reset_p2", lg_st[6], 2);
        #2 rst_n = 0;
        #1;
        chk("async_reset_a", {a_state, a_s1, a_s2, a_s3, a_w, a_c, a_busy}, 0);
        chk("async_reset_b", {b_state, b_s1, b_s2, b_s3, b_w, b_c, b_busy}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        run(20, 0, 0);
        chk("post_reset_no_done", sum_of(20, 0), 0);
        chk("post_reset_no_abort", sum_of(20, 1), 0);
        chk("post_reset_idle", lg_st[20], 0);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 8) == 0;
            abort = ($urandom % 40) == 0;
            cfg_dose = 16'($urandom % 8);
            @(posedge clk); #1;
        end
        start = 0;
        abort = 0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
